// File: rtl/rs_data_write_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_data_write_scheduler_pkg: shared sizes and write-request type         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rs_data_write_scheduler_pkg;

  localparam int NUM_REQ     = 4;
  localparam int NUM_WPORT   = 2;
  localparam int NUM_ENTRIES = 16;
  localparam int DATA_W      = 64;
  localparam int QDEPTH      = 2;

  typedef struct packed {
    logic [NUM_ENTRIES-1:0] addr;
    logic [DATA_W-1:0]      data;
  } wreq_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int RR_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

endpackage
`default_nettype wire

// File: rtl/rs_data_write_scheduler_wreq_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_wreq_fifo: per-requester write FIFO, wrap-bit pointers, addr summary  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rs_wreq_fifo
  import rs_data_write_scheduler_pkg::*;
#(
  parameter int DEPTH = QDEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  wreq_t                  push_req,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output wreq_t                  head,
  output logic [NUM_ENTRIES-1:0] addr_or
);

  localparam int PW = clog2(DEPTH);

  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  wreq_t         mem_q [DEPTH];
  wreq_t         mem_d [DEPTH];
  logic [PW:0]   count;
  logic [PW-1:0] slot_off;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // A full FIFO never accepts, even when its head pops this cycle.
      if (push && !full) begin
        mem_d[wr_ptr_q[PW-1:0]] = push_req;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    addr_or  = '0;
    slot_off = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_off = PW'(j) - rd_ptr_q[PW-1:0];
      if ({1'b0, slot_off} < count) addr_or = addr_or | mem_q[j].addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_data_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_data_write_scheduler: round-robin, conflict-free RS data write ports  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rs_data_write_scheduler
  import rs_data_write_scheduler_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_flush,
  input  logic                   io_req_0_valid,
  output logic                   io_req_0_ready,
  input  logic [NUM_ENTRIES-1:0] io_req_0_addr,
  input  logic [DATA_W-1:0]      io_req_0_data,
  input  logic                   io_req_1_valid,
  output logic                   io_req_1_ready,
  input  logic [NUM_ENTRIES-1:0] io_req_1_addr,
  input  logic [DATA_W-1:0]      io_req_1_data,
  input  logic                   io_req_2_valid,
  output logic                   io_req_2_ready,
  input  logic [NUM_ENTRIES-1:0] io_req_2_addr,
  input  logic [DATA_W-1:0]      io_req_2_data,
  input  logic                   io_req_3_valid,
  output logic                   io_req_3_ready,
  input  logic [NUM_ENTRIES-1:0] io_req_3_addr,
  input  logic [DATA_W-1:0]      io_req_3_data,
  output logic                   io_write_0_enable,
  output logic                   io_write_0_mask_0,
  output logic [NUM_ENTRIES-1:0] io_write_0_addr,
  output logic [DATA_W-1:0]      io_write_0_data_0,
  output logic                   io_write_1_enable,
  output logic                   io_write_1_mask_0,
  output logic [NUM_ENTRIES-1:0] io_write_1_addr,
  output logic [DATA_W-1:0]      io_write_1_data_0,
  output logic [NUM_ENTRIES-1:0] io_pending_vec,
  output logic                   io_idle,
  output logic                   io_perf_conflict
);

  logic [NUM_REQ-1:0]     req_valid;
  wreq_t                  req_in [NUM_REQ];
  logic [NUM_REQ-1:0]     fifo_full, fifo_empty, pop_vec;
  wreq_t                  fifo_head [NUM_REQ];
  logic [NUM_ENTRIES-1:0] fifo_addr_or [NUM_REQ];

  logic [NUM_WPORT-1:0]   grant_en;
  logic [RR_W-1:0]        grant_idx [NUM_WPORT];
  logic [NUM_ENTRIES-1:0] taken_mask;
  logic [RR_W:0]          taken_cnt;
  logic [RR_W-1:0]        scan_idx, last_idx;
  logic                   any_grant, conflict;

  logic [RR_W-1:0]        rr_q, rr_d;
  logic [NUM_WPORT-1:0]   wr_en_q, wr_en_d;
  logic [NUM_ENTRIES-1:0] wr_addr_q [NUM_WPORT];
  logic [NUM_ENTRIES-1:0] wr_addr_d [NUM_WPORT];
  logic [DATA_W-1:0]      wr_data_q [NUM_WPORT];
  logic [DATA_W-1:0]      wr_data_d [NUM_WPORT];
  logic [NUM_ENTRIES-1:0] pending;

  assign req_valid = {io_req_3_valid, io_req_2_valid, io_req_1_valid, io_req_0_valid};
  assign req_in[0] = {io_req_0_addr, io_req_0_data};
  assign req_in[1] = {io_req_1_addr, io_req_1_data};
  assign req_in[2] = {io_req_2_addr, io_req_2_data};
  assign req_in[3] = {io_req_3_addr, io_req_3_data};

  assign io_req_0_ready = !fifo_full[0];
  assign io_req_1_ready = !fifo_full[1];
  assign io_req_2_ready = !fifo_full[2];
  assign io_req_3_ready = !fifo_full[3];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    rs_wreq_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (io_flush),
      .push     (req_valid[i]),
      .push_req (req_in[i]),
      .pop      (pop_vec[i]),
      .full     (fifo_full[i]),
      .empty    (fifo_empty[i]),
      .head     (fifo_head[i]),
      .addr_or  (fifo_addr_or[i])
    );

    a_req_onehot: assert property (@(posedge clock) disable iff (reset)
      req_valid[i] |-> $onehot(req_in[i].addr));
  end

  // Round-robin scan from rr; the n-th head taken lands on write port n.
  always_comb begin
    pop_vec    = '0;
    grant_en   = '0;
    conflict   = 1'b0;
    any_grant  = 1'b0;
    taken_mask = '0;
    taken_cnt  = '0;
    last_idx   = rr_q;
    scan_idx   = rr_q;
    for (int p = 0; p < NUM_WPORT; p++) grant_idx[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = RR_W'((int'(rr_q) + k) % NUM_REQ);
      if (!fifo_empty[scan_idx]) begin
        if ((int'(taken_cnt) < NUM_WPORT) &&
            ((fifo_head[scan_idx].addr & taken_mask) == '0)) begin
          for (int p = 0; p < NUM_WPORT; p++) begin
            if (int'(taken_cnt) == p) begin
              grant_en[p]  = 1'b1;
              grant_idx[p] = scan_idx;
            end
          end
          pop_vec[scan_idx] = 1'b1;
          taken_mask        = taken_mask | fifo_head[scan_idx].addr;
          taken_cnt         = taken_cnt + 1'b1;
          last_idx          = scan_idx;
          any_grant         = 1'b1;
        end else begin
          conflict = 1'b1;
        end
      end
    end
    if (io_flush) begin
      pop_vec  = '0;
      conflict = 1'b0;
    end
  end

  always_comb begin
    wr_en_d = '0;
    rr_d    = rr_q;
    for (int p = 0; p < NUM_WPORT; p++) begin
      wr_addr_d[p] = wr_addr_q[p];
      wr_data_d[p] = wr_data_q[p];
    end
    if (!io_flush) begin
      wr_en_d = grant_en;
      for (int p = 0; p < NUM_WPORT; p++) begin
        if (grant_en[p]) begin
          wr_addr_d[p] = fifo_head[grant_idx[p]].addr;
          wr_data_d[p] = fifo_head[grant_idx[p]].data;
        end
      end
      if (any_grant) rr_d = (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q    <= '0;
      wr_en_q <= '0;
      for (int p = 0; p < NUM_WPORT; p++) begin
        wr_addr_q[p] <= '0;
        wr_data_q[p] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Staged writes still count as pending until the array has taken them.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) pending = pending | fifo_addr_or[i];
    for (int p = 0; p < NUM_WPORT; p++) begin
      if (wr_en_q[p]) pending = pending | wr_addr_q[p];
    end
  end

  assign io_pending_vec    = pending;
  assign io_idle           = (&fifo_empty) && !(|wr_en_q);
  assign io_perf_conflict  = conflict;

  assign io_write_0_enable = wr_en_q[0];
  assign io_write_0_mask_0 = wr_en_q[0];
  assign io_write_0_addr   = wr_addr_q[0];
  assign io_write_0_data_0 = wr_data_q[0];
  assign io_write_1_enable = wr_en_q[1];
  assign io_write_1_mask_0 = wr_en_q[1];
  assign io_write_1_addr   = wr_addr_q[1];
  assign io_write_1_data_0 = wr_data_q[1];

endmodule
`default_nettype wire

// File: tb/tb_rs_data_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs_data_write_scheduler: directed self-checking bench                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rs_data_write_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid [4];
  logic        req_ready [4];
  logic [15:0] req_addr  [4];
  logic [63:0] req_data  [4];
  logic        w0_en, w0_mask, w1_en, w1_mask;
  logic [15:0] w0_addr, w1_addr, pending;
  logic [63:0] w0_data, w1_data;
  logic        idle, perf_conflict;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  rs_data_write_scheduler dut (
    .clock(clock), .reset(reset), .io_flush(flush),
    .io_req_0_valid(req_valid[0]), .io_req_0_ready(req_ready[0]),
    .io_req_0_addr(req_addr[0]), .io_req_0_data(req_data[0]),
    .io_req_1_valid(req_valid[1]), .io_req_1_ready(req_ready[1]),
    .io_req_1_addr(req_addr[1]), .io_req_1_data(req_data[1]),
    .io_req_2_valid(req_valid[2]), .io_req_2_ready(req_ready[2]),
    .io_req_2_addr(req_addr[2]), .io_req_2_data(req_data[2]),
    .io_req_3_valid(req_valid[3]), .io_req_3_ready(req_ready[3]),
    .io_req_3_addr(req_addr[3]), .io_req_3_data(req_data[3]),
    .io_write_0_enable(w0_en), .io_write_0_mask_0(w0_mask),
    .io_write_0_addr(w0_addr), .io_write_0_data_0(w0_data),
    .io_write_1_enable(w1_en), .io_write_1_mask_0(w1_mask),
    .io_write_1_addr(w1_addr), .io_write_1_data_0(w1_data),
    .io_pending_vec(pending), .io_idle(idle), .io_perf_conflict(perf_conflict)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 16'h0001;
      req_data[i]  = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [63:0] d);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    #1;
    n_cmp++; if ({w0_en, w1_en, w0_mask, w1_mask} !== 4'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0000", {w0_en, w1_en, w0_mask, w1_mask}); end
    n_cmp++; if ({w0_addr, w1_addr} !== 32'h0 || {w0_data, w1_data} !== 128'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h %h want 0", {w0_addr, w1_addr}, {w0_data, w1_data}); end
    n_cmp++; if ({pending, idle, perf_conflict} !== {16'h0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_status: got pend=%h idle=%b conf=%b want 0000/1/0", pending, idle, perf_conflict); end
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if ({req_ready[0], req_ready[1], req_ready[2], req_ready[3]} !== 4'b1111) begin n_fail++; $display("FAIL reset_ready: got %b want 1111", {req_ready[0], req_ready[1], req_ready[2], req_ready[3]}); end
  endtask

  task automatic test_four_simultaneous();
    for (int i = 0; i < 4; i++) set_req(i, 16'h0001 << i, 64'h100 + 64'(i));
    tick();
    clear_reqs();
    n_cmp++; if (perf_conflict !== 1'b1 || w0_en !== 1'b0) begin n_fail++; $display("FAIL four_sel1: got conf=%b en0=%b want 1/0", perf_conflict, w0_en); end
    tick();
    n_cmp++; if ({w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data} !== {1'b1, 16'h1, 64'h100, 1'b1, 16'h2, 64'h101}) begin n_fail++; $display("FAIL four_first: got %b %h %h %b %h %h want req0/req1", w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data); end
    n_cmp++; if (perf_conflict !== 1'b0) begin n_fail++; $display("FAIL four_conf2: got %b want 0", perf_conflict); end
    tick();
    n_cmp++; if ({w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data} !== {1'b1, 16'h4, 64'h102, 1'b1, 16'h8, 64'h103}) begin n_fail++; $display("FAIL four_second: got %b %h %h %b %h %h want req2/req3", w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data); end
    n_cmp++; if (w0_mask !== 1'b1 || w1_mask !== 1'b1) begin n_fail++; $display("FAIL four_mask: got %b%b want 11", w0_mask, w1_mask); end
    tick();
    n_cmp++; if ({w0_en, w1_en, idle} !== 3'b001) begin n_fail++; $display("FAIL four_drain: got en=%b%b idle=%b want 00/1", w0_en, w1_en, idle); end
  endtask

  task automatic test_conflict();
    set_req(0, 16'h0010, 64'hA0);
    set_req(1, 16'h0010, 64'hA1);
    tick();
    clear_reqs();
    n_cmp++; if (perf_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag: got %b want 1", perf_conflict); end
    tick();
    n_cmp++; if ({w0_en, w0_addr, w0_data, w1_en} !== {1'b1, 16'h10, 64'hA0, 1'b0}) begin n_fail++; $display("FAIL conf_first: got %b %h %h en1=%b want 1 0010 a0 0", w0_en, w0_addr, w0_data, w1_en); end
    tick();
    n_cmp++; if ({w0_en, w0_addr, w0_data, w1_en} !== {1'b1, 16'h10, 64'hA1, 1'b0}) begin n_fail++; $display("FAIL conf_second: got %b %h %h en1=%b want 1 0010 a1 0", w0_en, w0_addr, w0_data, w1_en); end
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL conf_idle: got %b want 1", idle); end
  endtask

  task automatic test_single_write();
    set_req(0, 16'h0004, 64'hDEAD);
    tick();
    clear_reqs();
    n_cmp++; if ({pending[2], w0_en, idle} !== 3'b100) begin n_fail++; $display("FAIL single_c2: got pend2=%b en=%b idle=%b want 1/0/0", pending[2], w0_en, idle); end
    tick();
    n_cmp++; if ({w0_en, w0_mask, w0_addr, w0_data, w1_en, pending[2]} !== {2'b11, 16'h4, 64'hDEAD, 1'b0, 1'b1}) begin n_fail++; $display("FAIL single_c3: got %b%b %h %h en1=%b pend2=%b", w0_en, w0_mask, w0_addr, w0_data, w1_en, pending[2]); end
    tick();
    n_cmp++; if ({w0_en, pending, idle} !== {1'b0, 16'h0, 1'b1}) begin n_fail++; $display("FAIL single_c4: got en=%b pend=%h idle=%b want 0/0000/1", w0_en, pending, idle); end
    n_cmp++; if ({w0_addr, w0_data} !== {16'h4, 64'hDEAD}) begin n_fail++; $display("FAIL single_hold: got %h %h want 0004 dead", w0_addr, w0_data); end
  endtask

  task automatic test_back_to_back();
    set_req(2, 16'h0020, 64'hB0);
    tick();
    set_req(2, 16'h0040, 64'hB1);
    tick();
    set_req(2, 16'h0080, 64'hB2);
    n_cmp++; if ({w0_en, w0_addr, w0_data} !== {1'b1, 16'h20, 64'hB0}) begin n_fail++; $display("FAIL b2b_0: got %b %h %h want 1 0020 b0", w0_en, w0_addr, w0_data); end
    tick();
    clear_reqs();
    n_cmp++; if ({w0_en, w0_addr, w0_data, w1_en} !== {1'b1, 16'h40, 64'hB1, 1'b0}) begin n_fail++; $display("FAIL b2b_1: got %b %h %h en1=%b want 1 0040 b1 0", w0_en, w0_addr, w0_data, w1_en); end
    tick();
    n_cmp++; if ({w0_en, w0_addr, w0_data} !== {1'b1, 16'h80, 64'hB2}) begin n_fail++; $display("FAIL b2b_2: got %b %h %h want 1 0080 b2", w0_en, w0_addr, w0_data); end
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", idle); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) set_req(i, 16'h0001, 64'hC0 + 64'(i));
    tick();
    clear_reqs();
    tick();
    n_cmp++; if ({w0_en, w1_en, pending, idle} !== {2'b10, 16'h0001, 1'b0}) begin n_fail++; $display("FAIL flush_pre: got en=%b%b pend=%h idle=%b want 10/0001/0", w0_en, w1_en, pending, idle); end
    flush = 1'b1;
    set_req(0, 16'h8000, 64'hDD);
    tick();
    flush = 1'b0;
    clear_reqs();
    n_cmp++; if ({w0_en, w1_en, pending, idle} !== {2'b00, 16'h0, 1'b1}) begin n_fail++; $display("FAIL flush_post: got en=%b%b pend=%h idle=%b want 00/0000/1", w0_en, w1_en, pending, idle); end
    tick();
    n_cmp++; if ({w0_en, w1_en, pending, idle} !== {2'b00, 16'h0, 1'b1}) begin n_fail++; $display("FAIL flush_drop: got en=%b%b pend=%h idle=%b want 00/0000/1", w0_en, w1_en, pending, idle); end
  endtask

  task automatic test_stream();
    int sent [4];
    int rcvd [4];
    int grants [4];
    int seen_lo [4];
    int seen_hi [4];
    int id;
    logic [63:0] d;
    for (int i = 0; i < 4; i++) begin sent[i] = 0; rcvd[i] = 0; grants[i] = 0; seen_lo[i] = 0; seen_hi[i] = 0; end
    for (int c = 0; c < 130; c++) begin
      logic acc [4];
      for (int i = 0; i < 4; i++) begin
        if (c < 120) set_req(i, 16'h0100 << i, (64'(i) << 32) | 64'(sent[i]));
        else req_valid[i] = 1'b0;
        acc[i] = req_valid[i] && req_ready[i];
        if (c >= 5 && c < 120) begin
          if (req_ready[i]) seen_hi[i]++; else seen_lo[i]++;
        end
      end
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? w0_en : w1_en) begin
          d  = (p == 0) ? w0_data : w1_data;
          id = int'(d[39:32]);
          if (id > 3) id = 0;
          n_cmp++; if (d[31:0] !== 32'(rcvd[id])) begin n_fail++; $display("FAIL stream_order: req%0d got seq %0d want %0d", id, d[31:0], rcvd[id]); end
          rcvd[id]++;
          if (c >= 10 && c < 110) grants[id]++;
        end
      end
      if (w0_en && w1_en) begin
        n_cmp++; if (w0_addr === w1_addr) begin n_fail++; $display("FAIL stream_same_addr: got %h on both ports want distinct", w0_addr); end
      end
    end
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (grants[i] < 49 || grants[i] > 51) begin n_fail++; $display("FAIL stream_fair: req%0d got %0d grants want 49..51", i, grants[i]); end
      n_cmp++; if (rcvd[i] !== sent[i]) begin n_fail++; $display("FAIL stream_count: req%0d got %0d writes want %0d", i, rcvd[i], sent[i]); end
      n_cmp++; if (seen_lo[i] == 0 || seen_hi[i] == 0) begin n_fail++; $display("FAIL stream_ready: req%0d got lo=%0d hi=%0d want both nonzero", i, seen_lo[i], seen_hi[i]); end
    end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL stream_idle: got %b want 1", idle); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 16'h0001, 64'hE0 + 64'(c));
      tick();
    end
    n_cmp++; if ({req_ready[0], req_ready[1], req_ready[2], req_ready[3]} === 4'b1111) begin n_fail++; $display("FAIL areset_fill: got ready=1111 want some FIFO full"); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({w0_en, w1_en, w0_mask, w1_mask, pending, idle, perf_conflict} !== {4'b0, 16'h0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL areset_status: got en=%b%b pend=%h idle=%b conf=%b want 00/0000/1/0", w0_en, w1_en, pending, idle, perf_conflict); end
    n_cmp++; if ({w0_addr, w1_addr, w0_data, w1_data} !== 160'h0) begin n_fail++; $display("FAIL areset_addr_data: got %h %h want 0", {w0_addr, w1_addr}, {w0_data, w1_data}); end
    clear_reqs();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if ({req_ready[0], req_ready[1], req_ready[2], req_ready[3], idle} !== 5'b11111) begin n_fail++; $display("FAIL areset_ready: got %b want 11111", {req_ready[0], req_ready[1], req_ready[2], req_ready[3], idle}); end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_four_simultaneous();
    test_conflict();
    test_single_write();
    test_back_to_back();
    test_flush();
    test_stream();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
